// File: rtl/dmem_wait.sv
// Data memory with valid/ready request/response handshake and LATENCY-cycle access.
// Optional build macro DMEM_MISALIGN_TRAP_EN: fault misaligned H/W accesses instead of aligning them.
module dmem_wait #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AW    = IDX_W + 2;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        mode_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx_c;
  logic [31:0]       word_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [31:0]       ld_c;
  logic [3:0]        be_c;
  logic [31:0]       wd_c;
  logic              bad_mode_c;
  logic              misalign_c;
  logic              err_c;
  logic              access_c;
  logic              wr_en_c;
  logic              unused_addr_c;

  // Address bits above the array size alias, so they are dropped at capture.
  assign unused_addr_c = ^req_addr[31:AW];

  assign idx_c  = addr_q[AW-1:2];
  assign word_c = mem[idx_c];
  assign half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];

  always_comb begin
    byte_c = word_c[7:0];
    case (addr_q[1:0])
      2'd1:    byte_c = word_c[15:8];
      2'd2:    byte_c = word_c[23:16];
      2'd3:    byte_c = word_c[31:24];
      default: byte_c = word_c[7:0];
    endcase
  end

  assign bad_mode_c = (mode_q != MODE_B) && (mode_q != MODE_H) && (mode_q != MODE_W) &&
                      (mode_q != MODE_BU) && (mode_q != MODE_HU);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_c = (((mode_q == MODE_H) || (mode_q == MODE_HU)) && addr_q[0]) ||
                      ((mode_q == MODE_W) && (addr_q[1:0] != 2'b00));
`else
  // Low address bits below the access size are simply not used for lane selection.
  assign misalign_c = 1'b0;
`endif

  assign err_c = bad_mode_c || misalign_c;

  // Load extraction and extension.
  always_comb begin
    ld_c = '0;
    case (mode_q)
      MODE_B:  ld_c = {{24{byte_c[7]}}, byte_c};
      MODE_BU: ld_c = {24'h0, byte_c};
      MODE_H:  ld_c = {{16{half_c[15]}}, half_c};
      MODE_HU: ld_c = {16'h0, half_c};
      MODE_W:  ld_c = word_c;
      default: ld_c = '0;
    endcase
  end

  // Store lane enables with data replicated across lanes.
  always_comb begin
    be_c = 4'b0000;
    wd_c = wdata_q;
    case (mode_q)
      MODE_B, MODE_BU: begin
        be_c = 4'b0001 << addr_q[1:0];
        wd_c = {4{wdata_q[7:0]}};
      end
      MODE_H, MODE_HU: begin
        be_c = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{wdata_q[15:0]}};
      end
      MODE_W:  be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // The access fires on the WAIT edge whose counter has run out, i.e. LATENCY edges after acceptance.
  assign access_c = (state == WAIT) && (cnt == '0);
  assign wr_en_c  = access_c && we_q && !err_c;

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wd_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      mode_q    <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            mode_q    <= req_mode;
            addr_q    <= req_addr[AW-1:0];
            wdata_q   <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (access_c) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_c;
            rsp_rdata <= (we_q || err_c) ? 32'h0 : ld_c;
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: three instances at LATENCY 1, 3 and 4 on a 64-word array.
module tb_dmem_wait;

  localparam int unsigned NI = 3;
  localparam int unsigned DEPTH = 64;
  localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010, M_BU = 3'b100, M_HU = 3'b101;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    int          k;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_valid_a [NI];
  logic        rsp_ready_a [NI];
  logic        req_ready_a [NI];
  logic        rsp_valid_a [NI];
  logic [31:0] rsp_rdata_a [NI];
  logic        rsp_err_a   [NI];

  int checks;
  int failures;
  int lat_of [NI];

  dmem_wait #(.DEPTH(DEPTH), .LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]), .rsp_rdata(rsp_rdata_a[0]),
    .rsp_err(rsp_err_a[0]));

  dmem_wait #(.DEPTH(DEPTH), .LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]), .rsp_rdata(rsp_rdata_a[1]),
    .rsp_err(rsp_err_a[1]));

  dmem_wait #(.DEPTH(DEPTH), .LATENCY(4)) u2 (
    .clk(clk), .reset(reset), .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
    .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready_a[2]), .rsp_rdata(rsp_rdata_a[2]),
    .rsp_err(rsp_err_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout reached without summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Issue one request, wait for its response, then hand it off with rsp_ready.
  task automatic do_vec(input vec_t v, output logic [31:0] rd, output logic er, output int lat);
    bit done;
    req_we    = v.we;
    req_mode  = v.mode;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid_a[v.k] = 1'b1;
    rsp_ready_a[v.k] = 1'b0;
    @(posedge clk); #1;
    req_valid_a[v.k] = 1'b0;
    lat  = 0;
    done = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(posedge clk); #1;
      if (rsp_valid_a[v.k]) begin
        lat  = n;
        done = 1'b1;
      end
    end
    rd = rsp_rdata_a[v.k];
    er = rsp_err_a[v.k];
    rsp_ready_a[v.k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a[v.k] = 1'b0;
  endtask

  vec_t        tv [$];
  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] exp10;
  logic [31:0] hold_rd;
  bit          seen;

  initial begin
    checks   = 0;
    failures = 0;
    lat_of   = '{1, 3, 4};
    reset    = 1'b0;
    req_we   = 1'b0;
    req_mode = M_W;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < NI; i++) begin
      req_valid_a[i] = 1'b0;
      rsp_ready_a[i] = 1'b0;
    end

    // u0, LATENCY=1: basic word access, lane merges, wrap-around
    tv.push_back('{0, 1'b1, M_W,  32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
    tv.push_back('{0, 1'b0, M_W,  32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
    tv.push_back('{0, 1'b1, M_W,  32'h20,       32'h11223344, 32'h0,        1'b0});
    tv.push_back('{0, 1'b1, M_B,  32'h21,       32'h123456AA, 32'h0,        1'b0});
    tv.push_back('{0, 1'b0, M_W,  32'h20,       32'h0,        32'h1122AA44, 1'b0});
    tv.push_back('{0, 1'b1, M_H,  32'h22,       32'h9999BEEF, 32'h0,        1'b0});
    tv.push_back('{0, 1'b0, M_W,  32'h20,       32'h0,        32'hBEEFAA44, 1'b0});
    tv.push_back('{0, 1'b0, M_HU, 32'h22,       32'h0,        32'h0000BEEF, 1'b0});
    tv.push_back('{0, 1'b0, M_H,  32'h22,       32'h0,        32'hFFFFBEEF, 1'b0});
    tv.push_back('{0, 1'b0, M_W,  32'h120,      32'h0,        32'hBEEFAA44, 1'b0});
    tv.push_back('{0, 1'b0, M_W,  32'h80000120, 32'h0,        32'hBEEFAA44, 1'b0});
    tv.push_back('{0, 1'b1, M_W,  32'hFC,       32'hA5A5A5A5, 32'h0,        1'b0});
    tv.push_back('{0, 1'b0, M_W,  32'h1FC,      32'h0,        32'hA5A5A5A5, 1'b0});
    tv.push_back('{0, 1'b0, 3'b110, 32'h20,     32'h0,        32'h0,        1'b1});
    // u1, LATENCY=3: extension cases, faults, misalignment
    tv.push_back('{1, 1'b1, M_W,  32'h10, 32'h80FF7F01, 32'h0,        1'b0});
    tv.push_back('{1, 1'b0, M_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0});
    tv.push_back('{1, 1'b0, M_BU, 32'h13, 32'h0,        32'h00000080, 1'b0});
    tv.push_back('{1, 1'b0, M_H,  32'h12, 32'h0,        32'hFFFF80FF, 1'b0});
    tv.push_back('{1, 1'b0, M_HU, 32'h12, 32'h0,        32'h000080FF, 1'b0});
    tv.push_back('{1, 1'b0, M_B,  32'h11, 32'h0,        32'h0000007F, 1'b0});
    tv.push_back('{1, 1'b0, M_H,  32'h10, 32'h0,        32'h00007F01, 1'b0});
    tv.push_back('{1, 1'b0, M_W,  32'h12, 32'h0,        TRAP ? 32'h0 : 32'h80FF7F01, TRAP});
    tv.push_back('{1, 1'b0, M_H,  32'h13, 32'h0,        TRAP ? 32'h0 : 32'hFFFF80FF, TRAP});
    tv.push_back('{1, 1'b0, 3'b111, 32'h10, 32'h0,      32'h0,        1'b1});
    tv.push_back('{1, 1'b1, 3'b011, 32'h10, 32'h0,      32'h0,        1'b1});
    tv.push_back('{1, 1'b0, M_W,  32'h10, 32'h0,        32'h80FF7F01, 1'b0});
    tv.push_back('{1, 1'b1, M_W,  32'h11, 32'h0,        32'h0,        TRAP});
    tv.push_back('{1, 1'b0, M_W,  32'h10, 32'h0,        TRAP ? 32'h80FF7F01 : 32'h0, 1'b0});
    // u2, LATENCY=4: seed the word used by the reset-abort sequence
    tv.push_back('{2, 1'b1, M_W,  32'h20, 32'h0,        32'h0,        1'b0});
    tv.push_back('{2, 1'b0, M_W,  32'h20, 32'h0,        32'h0,        1'b0});
    exp10 = TRAP ? 32'h80FF7F01 : 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d_req_ready", i), 32'(req_ready_a[i]), 32'h0);
      chk($sformatf("rst%0d_rsp_valid", i), 32'(rsp_valid_a[i]), 32'h0);
      chk($sformatf("rst%0d_rsp_rdata", i), rsp_rdata_a[i], 32'h0);
      chk($sformatf("rst%0d_rsp_err", i), 32'(rsp_err_a[i]), 32'h0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) chk($sformatf("post_rst%0d_req_ready", i), 32'(req_ready_a[i]), 32'h1);

    // Vector table
    for (int i = 0; i < tv.size(); i++) begin
      do_vec(tv[i], rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(lat_of[tv[i].k]));
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].err));
      chk($sformatf("vec%0d_rsp_valid_drop", i), 32'(rsp_valid_a[tv[i].k]), 32'h0);
      chk($sformatf("vec%0d_req_ready_back", i), 32'(req_ready_a[tv[i].k]), 32'h1);
    end

    // Backpressure on u1 with request inputs wiggling while busy
    req_we = 1'b0; req_mode = M_W; req_addr = 32'h10; req_wdata = '0;
    req_valid_a[1] = 1'b1;
    rsp_ready_a[1] = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'hFFFFFFFF; req_addr = 32'h10;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      seen = rsp_valid_a[1];
    end
    chk("bp_rsp_valid_seen", 32'(seen), 32'h1);
    hold_rd = rsp_rdata_a[1];
    chk("bp_rdata", hold_rd, exp10);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_rsp_valid", n), 32'(rsp_valid_a[1]), 32'h1);
      chk($sformatf("bp_hold%0d_rdata", n), rsp_rdata_a[1], exp10);
      chk($sformatf("bp_hold%0d_err", n), 32'(rsp_err_a[1]), 32'h0);
      chk($sformatf("bp_hold%0d_req_ready", n), 32'(req_ready_a[1]), 32'h0);
    end
    rsp_ready_a[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_rsp_valid", 32'(rsp_valid_a[1]), 32'h0);
    chk("bp_release_req_ready", 32'(req_ready_a[1]), 32'h1);
    req_valid_a[1] = 1'b0;
    rsp_ready_a[1] = 1'b0;
    do_vec('{1, 1'b0, M_W, 32'h10, 32'h0, 32'h0, 1'b0}, rd, er, lat);
    chk("bp_store_ignored", rd, exp10);

    // Reset two cycles into a LATENCY=4 store on u2
    req_we = 1'b1; req_mode = M_W; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid_a[2] = 1'b1;
    @(posedge clk); #1;
    req_valid_a[2] = 1'b0;
    chk("abort_accepted", 32'(req_ready_a[2]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_in_rst_rsp_valid", 32'(rsp_valid_a[2]), 32'h0);
    chk("abort_in_rst_req_ready", 32'(req_ready_a[2]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_post_req_ready", 32'(req_ready_a[2]), 32'h1);
    chk("abort_post_rsp_valid", 32'(rsp_valid_a[2]), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_late_rsp", 32'(rsp_valid_a[2]), 32'h0);
    do_vec('{2, 1'b0, M_W, 32'h20, 32'h0, 32'h0, 1'b0}, rd, er, lat);
    chk("abort_store_discarded", rd, 32'h0);
    chk("abort_load_err", 32'(er), 32'h0);
    chk("abort_load_latency", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
